// File: rtl/vga_plot_sink.sv
// vga_plot_sink
// -------------
// Consumer end of the pixel-plot interface (x, y, colour, plot). Every
// in-range plot is written into an internal WIDTH x HEIGHT x CW framebuffer.
// A scan_start request reads the whole framebuffer back in raster order over
// a valid/ready pixel stream.
//
// Ports:
//   CLOCK_50     sole clock, rising edge
//   reset        asynchronous, active-high reset
//   vga_x/vga_y  plot coordinates
//   vga_colour   plot colour
//   vga_plot     write strobe, one write per cycle while high
//   scan_start   request a full raster readout (pulse or level)
//   pix_ready    downstream accepts the presented pixel
//   pix_valid    pix_x/pix_y/pix_colour/pix_last are valid
//   pix_x/pix_y  coordinates of the presented pixel
//   pix_colour   stored colour at (pix_x, pix_y)
//   pix_last     high with the pixel at (WIDTH-1, HEIGHT-1)
//   scan_busy    scan in progress
//   plot_count   accepted in-range plots, saturating
//   oob_count    rejected out-of-range plots, saturating
//   dbg_state    current read FSM state (0 IDLE, 1 RD, 2 PRES)
//
// Pixel stream handshake: a pixel transfers on a rising edge where
// pix_valid and pix_ready are both high. Once pix_valid is high the pix_*
// fields stay unchanged until that transfer; pix_valid never drops without
// a transfer (reset excepted). pix_ready may change freely.
module vga_plot_sink #(
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 120,
  parameter int XW     = 8,
  parameter int YW     = 7,
  parameter int CW     = 3
) (
  input  logic          CLOCK_50,
  input  logic          reset,
  input  logic [XW-1:0] vga_x,
  input  logic [YW-1:0] vga_y,
  input  logic [CW-1:0] vga_colour,
  input  logic          vga_plot,
  input  logic          scan_start,
  input  logic          pix_ready,
  output logic          pix_valid,
  output logic [XW-1:0] pix_x,
  output logic [YW-1:0] pix_y,
  output logic [CW-1:0] pix_colour,
  output logic          pix_last,
  output logic          scan_busy,
  output logic [14:0]   plot_count,
  output logic [7:0]    oob_count,
  output logic [1:0]    dbg_state
);

  localparam int NPIX = WIDTH * HEIGHT;
  localparam int AW   = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    PRES = 2'd2
  } state_t;

  state_t        state;
  logic [AW-1:0] rd_addr;
  logic [CW-1:0] mem [0:NPIX-1];

  logic          in_range;
  logic [AW-1:0] wr_addr;

  assign in_range = (int'(vga_x) < WIDTH) && (int'(vga_y) < HEIGHT);
  // Constant multiply; for WIDTH=160 this reduces to (y<<7)+(y<<5)+x.
  assign wr_addr  = AW'(vga_y) * AW'(WIDTH) + AW'(vga_x);
  assign dbg_state = state;

  // Framebuffer write port. Deliberately outside the reset domain so that
  // reset leaves the picture intact.
  always_ff @(posedge CLOCK_50) begin
    if (vga_plot && in_range) begin
      mem[wr_addr] <= vga_colour;
    end
  end

  // Plot statistics, both saturating at all-ones.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      plot_count <= '0;
      oob_count  <= '0;
    end else if (vga_plot) begin
      if (in_range) begin
        if (plot_count != '1) plot_count <= plot_count + 15'd1;
      end else begin
        if (oob_count != '1) oob_count <= oob_count + 8'd1;
      end
    end
  end

  // Read FSM. The memory read in RD is a registered read, so a write to the
  // same address on the same edge is not seen: the old colour is presented.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      rd_addr    <= '0;
      pix_valid  <= 1'b0;
      pix_x      <= '0;
      pix_y      <= '0;
      pix_colour <= '0;
      pix_last   <= 1'b0;
      scan_busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (scan_start) begin
            rd_addr   <= '0;
            pix_x     <= '0;
            pix_y     <= '0;
            scan_busy <= 1'b1;
            state     <= RD;
          end
        end
        RD: begin
          pix_colour <= mem[rd_addr];
          pix_last   <= (rd_addr == AW'(NPIX - 1));
          pix_valid  <= 1'b1;
          state      <= PRES;
        end
        PRES: begin
          if (pix_ready) begin
            pix_valid <= 1'b0;
            if (pix_last) begin
              pix_last  <= 1'b0;
              scan_busy <= 1'b0;
              state     <= IDLE;
            end else begin
              rd_addr <= rd_addr + AW'(1);
              if (pix_x == XW'(WIDTH - 1)) begin
                pix_x <= '0;
                pix_y <= pix_y + YW'(1);
              end else begin
                pix_x <= pix_x + XW'(1);
              end
              state <= RD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_plot_sink.sv
module tb_vga_plot_sink;

  localparam int WIDTH  = 160;
  localparam int HEIGHT = 120;
  localparam int XW     = 8;
  localparam int YW     = 7;
  localparam int CW     = 3;
  localparam int NPIX   = WIDTH * HEIGHT;

  // ---------------- clock / reset ----------------
  logic CLOCK_50 = 1'b0;
  logic reset    = 1'b1;
  initial forever #5 CLOCK_50 = ~CLOCK_50;

  logic [XW-1:0] vga_x      = '0;
  logic [YW-1:0] vga_y      = '0;
  logic [CW-1:0] vga_colour = '0;
  logic          vga_plot   = 1'b0;
  logic          scan_start = 1'b0;
  logic          pix_ready  = 1'b1;
  logic          rand_ready = 1'b0;

  logic          pix_valid;
  logic [XW-1:0] pix_x;
  logic [YW-1:0] pix_y;
  logic [CW-1:0] pix_colour;
  logic          pix_last;
  logic          scan_busy;
  logic [14:0]   plot_count;
  logic [7:0]    oob_count;
  logic [1:0]    dbg_state;

  vga_plot_sink #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .XW(XW), .YW(YW), .CW(CW)) dut (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .vga_x     (vga_x),
    .vga_y     (vga_y),
    .vga_colour(vga_colour),
    .vga_plot  (vga_plot),
    .scan_start(scan_start),
    .pix_ready (pix_ready),
    .pix_valid (pix_valid),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .pix_colour(pix_colour),
    .pix_last  (pix_last),
    .scan_busy (scan_busy),
    .plot_count(plot_count),
    .oob_count (oob_count),
    .dbg_state (dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // pix_ready is either held high or randomised once per cycle.
  always @(posedge CLOCK_50) begin
    #1;
    pix_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // ---------------- behavioural reference model ----------------
  // Framebuffer as a plain array; the scan is a pixel index that advances
  // one pixel per accepted transfer, each pixel shown one cycle after it is
  // requested, with the colour the framebuffer held before that edge's write.
  logic [CW-1:0] model_mem   [NPIX];
  bit            model_known [NPIX];
  bit            m_busy = 0, m_valid = 0, m_col_known = 0;
  int            m_idx = 0, m_plots = 0, m_oob = 0;
  logic [CW-1:0] m_col = '0;

  always @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      m_busy = 0; m_valid = 0; m_idx = 0; m_plots = 0; m_oob = 0;
    end else begin
      if (!m_busy) begin
        if (scan_start) begin m_busy = 1; m_valid = 0; m_idx = 0; end
      end else if (!m_valid) begin
        m_valid = 1;
        m_col = model_mem[m_idx];
        m_col_known = model_known[m_idx];
      end else if (pix_ready) begin
        m_valid = 0;
        if (m_idx == NPIX - 1) m_busy = 0;
        else m_idx++;
      end
      if (vga_plot) begin
        if (int'(vga_x) < WIDTH && int'(vga_y) < HEIGHT) begin
          model_mem[int'(vga_y) * WIDTH + int'(vga_x)] = vga_colour;
          model_known[int'(vga_y) * WIDTH + int'(vga_x)] = 1;
          if (m_plots < 32767) m_plots++;
        end else if (m_oob < 255) m_oob++;
      end
    end
  end

  // ---------------- compare process (scoreboard) ----------------
  int            hs_count = 0, last_cnt = 0;
  logic [XW-1:0] last_x = '0;
  logic [YW-1:0] last_y = '0;
  logic [CW-1:0] cap10 = 3'd7, cap20 = 3'd7;

  always @(negedge CLOCK_50) begin
    chk("scan_busy", 32'(scan_busy), 32'(m_busy));
    chk("pix_valid", 32'(pix_valid), 32'(m_valid));
    chk("plot_count", 32'(plot_count), 32'(m_plots));
    chk("oob_count", 32'(oob_count), 32'(m_oob));
    if (m_valid) begin
      chk("pix_x", 32'(pix_x), 32'(m_idx % WIDTH));
      chk("pix_y", 32'(pix_y), 32'(m_idx / WIDTH));
      chk("pix_last", 32'(pix_last), 32'(m_idx == NPIX - 1));
      if (m_col_known) chk("pix_colour", 32'(pix_colour), 32'(m_col));
    end
    if (pix_valid && pix_y == 0 && pix_x == 10) cap10 = pix_colour;
    if (pix_valid && pix_y == 0 && pix_x == 20) cap20 = pix_colour;
    if (pix_valid && pix_ready) begin
      hs_count++;
      if (pix_last) begin last_cnt++; last_x = pix_x; last_y = pix_y; end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic plot(input int x, input int y, input int c);
    vga_x = XW'(x); vga_y = YW'(y); vga_colour = CW'(c); vga_plot = 1'b1;
    tick();
    vga_plot = 1'b0;
  endtask

  task automatic fill(input int mode);  // mode 0: colour=x%8, else colour 0
    for (int y = 0; y < HEIGHT; y++)
      for (int x = 0; x < WIDTH; x++) begin
        vga_x = XW'(x); vga_y = YW'(y);
        vga_colour = (mode == 0) ? CW'(x % 8) : '0;
        vga_plot = 1'b1;
        tick();
      end
    vga_plot = 1'b0;
  endtask

  task automatic pulse_scan();
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
  endtask

  task automatic wait_pix(input string name, input int x, input int y, input int budget);
    bit found = 0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge CLOCK_50);
      if (pix_valid && int'(pix_x) == x && int'(pix_y) == y) found = 1;
    end
    chk(name, 32'(found), 32'd1);
  endtask

  task automatic wait_idle(input string name, input int budget);
    bit done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge CLOCK_50);
      if (!scan_busy) done = 1;
    end
    chk(name, 32'(done), 32'd1);
  endtask

  task automatic hit_reset();
    #2;
    reset = 1'b1;
    #1;
    chk("rst_pix_valid", 32'(pix_valid), 32'd0);
    chk("rst_scan_busy", 32'(scan_busy), 32'd0);
    chk("rst_pix_x", 32'(pix_x), 32'd0);
    chk("rst_pix_y", 32'(pix_y), 32'd0);
    tick();
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int hs0, last0;

  initial begin
    // 1. reset held with plotting active
    vga_plot = 1'b1; vga_x = 8'd3; vga_y = 7'd4; vga_colour = 3'd5;
    repeat (4) tick();
    @(negedge CLOCK_50);
    chk("reset_plot_count", 32'(plot_count), 32'd0);
    chk("reset_oob_count", 32'(oob_count), 32'd0);
    chk("reset_pix_valid", 32'(pix_valid), 32'd0);
    chk("reset_pix_last", 32'(pix_last), 32'd0);
    chk("reset_pix_colour", 32'(pix_colour), 32'd0);
    chk("reset_scan_busy", 32'(scan_busy), 32'd0);
    chk("reset_xy", 32'({pix_x, pix_y}), 32'd0);
    vga_plot = 1'b0;
    tick();
    reset = 1'b0;
    tick();

    // 2. full fill with colour = x%8
    fill(0);
    @(negedge CLOCK_50);
    chk("fill_plot_count", 32'(plot_count), 32'd19200);

    // 4. out-of-range plots
    plot(160, 0, 1);
    plot(0, 120, 2);
    plot(255, 127, 3);
    @(negedge CLOCK_50);
    chk("oob_three", 32'(oob_count), 32'd3);
    chk("oob_plot_count", 32'(plot_count), 32'd19200);
    for (int i = 0; i < 300; i++)
      plot($urandom_range(160, 255), $urandom_range(0, 127), $urandom_range(0, 7));
    @(negedge CLOCK_50);
    chk("oob_saturate", 32'(oob_count), 32'd255);

    // 2 (cont). full scan with pix_ready high; contents must be unaltered
    tick();
    hs0 = hs_count; last0 = last_cnt;
    pulse_scan();
    wait_idle("full_scan_end", 2 * NPIX + 20);
    chk("full_scan_handshakes", 32'(hs_count - hs0), 32'd19200);
    chk("full_scan_last_cnt", 32'(last_cnt - last0), 32'd1);
    chk("full_scan_last_x", 32'(last_x), 32'd159);
    chk("full_scan_last_y", 32'(last_y), 32'd119);

    // 3/6. backpressure scan, ignored restart, reset mid-scan
    tick();
    plot(0, 0, 6);
    plot(1, 0, 7);
    rand_ready = 1'b1;
    pulse_scan();
    wait_pix("bp_reach_20_1", 20, 1, 4000);
    tick();
    scan_start = 1'b1;
    repeat (3) tick();
    scan_start = 1'b0;
    @(negedge CLOCK_50);
    chk("busy_restart_ignored", 32'((int'(pix_y) * WIDTH + int'(pix_x)) >= 180), 32'd1);
    chk("busy_restart_busy", 32'(scan_busy), 32'd1);
    wait_pix("bp_reach_50_3", 50, 3, 8000);
    hit_reset();
    rand_ready = 1'b0;
    tick();
    pulse_scan();
    wait_pix("restart_first", 0, 0, 10);
    chk("restart_colour_0_0", 32'(pix_colour), 32'd6);
    wait_pix("restart_second", 1, 0, 10);
    chk("restart_colour_1_0", 32'(pix_colour), 32'd7);
    hit_reset();

    // 5. concurrent write and scan
    fill(1);
    pulse_scan();                 // sampled at edge E0
    repeat (20) tick();
    plot(10, 0, 5);               // lands on edge E0+21, the read edge of (10,0)
    plot(20, 0, 5);               // lands well before the read of (20,0)
    wait_pix("conc_reach_21", 21, 0, 100);
    chk("same_edge_old_data", 32'(cap10), 32'd0);
    chk("early_write_new_data", 32'(cap20), 32'd5);
    hit_reset();
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
